alu_result_stage: RTL and testbench

- Downstream neighbour of the 8:1 result mux in the 64-bit ALU datapath.
- Captures the selected operation result together with its op select, computes status flags (Z, N, C, V), and buffers the result in a 2-entry in-order FIFO.
- Presents results to the writeback/consumer through a valid/ready handshake, so the ALU can keep issuing while the consumer stalls for up to two results.

---
 rtl/alu_result_stage.sv | 76 +++++++
 tb/tb_alu_result_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: flag generation and 2-entry in-order result FIFO behind the ALU result mux.
// Define ALU_RES_STATS_EN to add saturating pop counters res_count and zero_count.
module alu_result_stage #(
    parameter int W = 64,
    parameter int DEPTH = 2
) (
`ifdef ALU_RES_STATS_EN
    output logic [15:0]  res_count,
    output logic [15:0]  zero_count,
`endif
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [2:0]   in_sel,
    input  logic         in_carry,
    input  logic         in_ovf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [2:0]   out_op,
    output logic [3:0]   out_flags
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0] mem_data [DEPTH];
    logic [2:0]   mem_op   [DEPTH];
    logic [3:0]   mem_flags[DEPTH];
    logic [CW-1:0] count;
    logic wptr, rptr, push, pop, arith;
    logic [3:0] flags;
    // Carry and overflow only mean something for add (0) and sub (1).
    always_comb begin
        arith = in_sel[2:1] == 2'b00;
        flags = {in_data == '0, in_data[W-1], arith & in_carry, arith & in_ovf};
        in_ready = count < CW'(DEPTH);
        out_valid = count != '0;
        push = in_valid && in_ready;
        pop = out_valid && out_ready;
        out_data = mem_data[rptr];
        out_op = mem_op[rptr];
        out_flags = mem_flags[rptr];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wptr <= 1'b0;
            rptr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_op[i] <= '0;
                mem_flags[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_data[wptr] <= in_data;
                mem_op[wptr] <= in_sel;
                mem_flags[wptr] <= flags;
                wptr <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            count <= count + CW'(push) - CW'(pop);
        end
    end
`ifdef ALU_RES_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_count <= '0;
            zero_count <= '0;
        end else begin
            if (pop && res_count != 16'hFFFF) res_count <= res_count + 16'd1;
            if (pop && out_flags[3] && zero_count != 16'hFFFF) zero_count <= zero_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed vector table plus hand-written sequences for alu_result_stage (W=8).
module tb_alu_result_stage;
    localparam int W = 8;
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_carry = 1'b0, in_ovf = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid;
    logic [W-1:0] in_data = '0, out_data;
    logic [2:0] in_sel = '0, out_op;
    logic [3:0] out_flags;
`ifdef ALU_RES_STATS_EN
    logic [15:0] res_count, zero_count;
`endif
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.W(W)) dut (
`ifdef ALU_RES_STATS_EN
        .res_count(res_count),
        .zero_count(zero_count),
`endif
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_sel(in_sel),
        .in_carry(in_carry),
        .in_ovf(in_ovf),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_op(out_op),
        .out_flags(out_flags)
    );

    typedef struct {
        logic v; logic [7:0] d; logic [2:0] s; logic c; logic o; logic rdy;
        logic ev; logic er; logic [7:0] ed; logic [2:0] eo; logic [3:0] ef;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [3:0] exp_flags(logic [7:0] d, logic [2:0] s, logic c, logic o);
        return {d == 8'd0, d[7], (s < 3'd2) & c, (s < 3'd2) & o};
    endfunction

    logic [7:0] sd[10];
    logic [2:0] ss[10];
    logic sc[10], so[10];

    initial begin
        // valid data sel c o rdy | exp: valid in_ready data op flags (all after the edge)
        tbl[0]  = '{1'b1, 8'h80, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 3'd0, 4'b0111};
        tbl[1]  = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 4'b0000};
        tbl[2]  = '{1'b1, 8'h00, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 3'd5, 4'b1000};
        tbl[3]  = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 4'b0000};
        tbl[4]  = '{1'b1, 8'h03, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 3'd0, 4'b0000};
        tbl[5]  = '{1'b1, 8'hF9, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 3'd0, 4'b0000};
        tbl[6]  = '{1'b1, 8'h0C, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 3'd0, 4'b0000};
        tbl[7]  = '{1'b1, 8'h0C, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hF9, 3'd1, 4'b0110};
        tbl[8]  = '{1'b1, 8'h0C, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hF9, 3'd1, 4'b0110};
        tbl[9]  = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0C, 3'd2, 4'b0000};
        tbl[10] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 4'b0000};
        tbl[11] = '{1'b1, 8'hFE, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFE, 3'd7, 4'b0100};
        tbl[12] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 4'b0000};

        #12;
        chk("rst out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst in_ready", 64'(in_ready), 64'(1'b1));
        chk("rst out_data", 64'(out_data), 64'(8'h00));
        chk("rst out_op", 64'(out_op), 64'(3'd0));
        chk("rst out_flags", 64'(out_flags), 64'(4'd0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            in_valid = tbl[i].v; in_data = tbl[i].d; in_sel = tbl[i].s;
            in_carry = tbl[i].c; in_ovf = tbl[i].o; out_ready = tbl[i].rdy;
            step();
            chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
            chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(tbl[i].er));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d out_data", i), 64'(out_data), 64'(tbl[i].ed));
                chk($sformatf("vec%0d out_op", i), 64'(out_op), 64'(tbl[i].eo));
                chk($sformatf("vec%0d out_flags", i), 64'(out_flags), 64'(tbl[i].ef));
            end
        end

        // Continuous push+pop: each result appears exactly one cycle after it is offered.
        for (int i = 0; i < 10; i++) begin
            sd[i] = 8'($urandom); ss[i] = 3'($urandom_range(0, 7));
            sc[i] = 1'($urandom); so[i] = 1'($urandom);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = sd[i]; in_sel = ss[i]; in_carry = sc[i]; in_ovf = so[i];
            step();
            chk($sformatf("stream%0d out_valid", i), 64'(out_valid), 64'(1'b1));
            chk($sformatf("stream%0d in_ready", i), 64'(in_ready), 64'(1'b1));
            chk($sformatf("stream%0d out_data", i), 64'(out_data), 64'(sd[i]));
            chk($sformatf("stream%0d out_op", i), 64'(out_op), 64'(ss[i]));
            chk($sformatf("stream%0d out_flags", i), 64'(out_flags),
                64'(exp_flags(sd[i], ss[i], sc[i], so[i])));
        end
        in_valid = 1'b0;
        step();
        chk("stream drain out_valid", 64'(out_valid), 64'(1'b0));

        // Fill both entries, then reset asynchronously between edges.
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd0; in_carry = 1'b1; in_ovf = 1'b1;
        in_data = 8'h11; step();
        in_data = 8'h22; step();
        chk("full in_ready", 64'(in_ready), 64'(1'b0));
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 64'(out_valid), 64'(1'b0));
        chk("midrst in_ready", 64'(in_ready), 64'(1'b1));
        chk("midrst out_data", 64'(out_data), 64'(8'h00));
        chk("midrst out_op", 64'(out_op), 64'(3'd0));
        chk("midrst out_flags", 64'(out_flags), 64'(4'd0));
        #2 rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        step();
        chk("post rst no stale", 64'(out_valid), 64'(1'b0));
        step();
        chk("post rst still empty", 64'(out_valid), 64'(1'b0));

`ifdef ALU_RES_STATS_EN
        chk("stats rst res_count", 64'(res_count), 64'(16'd0));
        chk("stats rst zero_count", 64'(zero_count), 64'(16'd0));
        in_sel = 3'd3;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = (i % 2 == 1) ? 8'h00 : 8'(i + 1);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("stats res_count", 64'(res_count), 64'(16'd5));
        chk("stats zero_count", 64'(zero_count), 64'(16'd2));
        in_valid = 1'b1; in_data = 8'h05;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        step();
        chk("stats res_count sat", 64'(res_count), 64'(16'hFFFF));
        chk("stats zero_count hold", 64'(zero_count), 64'(16'd2));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
